// File: rtl/ysyx_23060184_clint_pkg.sv
// Shared CLINT configuration: bus widths, register offsets, response codes,
// FSM state types and small decode/merge helpers.
package ysyx_23060184_clint_pkg;
   localparam int DATA_WIDTH   = 32;
   localparam int ADDR_WIDTH   = 32;
   localparam int ACERR_WIDTH  = 2;
   localparam int WMASK_LENGTH = 4;

   localparam logic [ADDR_WIDTH-1:0] OFF_MTIMECMP_LO = 32'h0000_4000;
   localparam logic [ADDR_WIDTH-1:0] OFF_MTIMECMP_HI = 32'h0000_4004;
   localparam logic [ADDR_WIDTH-1:0] OFF_MTIME_LO    = 32'h0000_BFF8;
   localparam logic [ADDR_WIDTH-1:0] OFF_MTIME_HI    = 32'h0000_BFFC;

   localparam logic [ACERR_WIDTH-1:0] OKAY   = 2'b00;
   localparam logic [ACERR_WIDTH-1:0] SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_DATA} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
   typedef enum logic [2:0] {SEL_NONE, SEL_CMP_LO, SEL_CMP_HI, SEL_MTIME_LO, SEL_MTIME_HI} reg_sel_e;

   // Exact match only, so misaligned offsets fall through to SEL_NONE.
   function automatic reg_sel_e decode_offset(input logic [ADDR_WIDTH-1:0] off);
      case (off)
         OFF_MTIMECMP_LO: decode_offset = SEL_CMP_LO;
         OFF_MTIMECMP_HI: decode_offset = SEL_CMP_HI;
         OFF_MTIME_LO:    decode_offset = SEL_MTIME_LO;
         OFF_MTIME_HI:    decode_offset = SEL_MTIME_HI;
         default:         decode_offset = SEL_NONE;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0]   old_word,
                                                        input logic [DATA_WIDTH-1:0]   new_word,
                                                        input logic [WMASK_LENGTH-1:0] strb);
      merge_word = old_word;
      for (int i = 0; i < WMASK_LENGTH; i++)
         if (strb[i]) merge_word[8*i +: 8] = new_word[8*i +: 8];
   endfunction
endpackage

// File: rtl/ysyx_23060184_clint_if.sv
// AXI-lite style register bus between a master and the CLINT.
interface ysyx_23060184_clint_if;
   import ysyx_23060184_clint_pkg::*;

   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid;
   logic                    aready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [ACERR_WIDTH-1:0]  rresp;
   logic                    rvalid;
   logic                    rready;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [WMASK_LENGTH-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic                    bvalid;
   logic [ACERR_WIDTH-1:0]  bresp;
   logic                    bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  aready, rdata, rresp, rvalid, awready, wready, bvalid, bresp
   );
   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output aready, rdata, rresp, rvalid, awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/ysyx_23060184_clint_timer.sv
// Prescaled 64-bit mtime, mtimecmp storage with a word write port, and the
// registered compare that drives the timer interrupt.
module ysyx_23060184_clint_timer
   import ysyx_23060184_clint_pkg::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  reg_sel_e                wr_sel,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [WMASK_LENGTH-1:0] wr_strb,
   output logic [63:0]             mtime,
   output logic [63:0]             mtimecmp,
   output logic                    timer_irq
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] prescale;
   logic          tick;
   logic          wr_mtime;

   assign tick     = (prescale == PRE_MAX);
   assign wr_mtime = wr_en && (wr_sel == SEL_MTIME_LO || wr_sel == SEL_MTIME_HI);

   always_ff @(posedge clk) begin
      if (reset) begin
         prescale  <= '0;
         mtime     <= '0;
         mtimecmp  <= '1;
         timer_irq <= 1'b0;
      end else begin
         timer_irq <= (mtime >= mtimecmp);
         // A software write to mtime restarts the prescaler and suppresses that cycle's tick.
         if (wr_mtime || tick) prescale <= '0;
         else                  prescale <= prescale + PW'(1);

         if (wr_en && wr_sel == SEL_MTIME_LO)
            mtime[31:0] <= merge_word(mtime[31:0], wr_data, wr_strb);
         else if (wr_en && wr_sel == SEL_MTIME_HI)
            mtime[63:32] <= merge_word(mtime[63:32], wr_data, wr_strb);
         else if (tick)
            mtime <= mtime + 64'd1;

         if (wr_en && wr_sel == SEL_CMP_LO)
            mtimecmp[31:0] <= merge_word(mtimecmp[31:0], wr_data, wr_strb);
         if (wr_en && wr_sel == SEL_CMP_HI)
            mtimecmp[63:32] <= merge_word(mtimecmp[63:32], wr_data, wr_strb);
      end
   end
endmodule

// File: rtl/ysyx_23060184_clint.sv
// CLINT top: independent read and write bus FSMs in front of the timer block.
module ysyx_23060184_clint
   import ysyx_23060184_clint_pkg::*;
#(
   parameter int                    TICK_DIV = 1,
   parameter logic [ADDR_WIDTH-1:0] BASE     = 32'h0200_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   ysyx_23060184_clint_if.slave   bus,
   output logic                   timer_irq
);
   rd_state_e               rd_state, rd_next;
   wr_state_e               wr_state, wr_next;
   reg_sel_e                rd_sel, wr_sel;
   logic                    ar_hs, r_hs, aw_hs, w_hs;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [ACERR_WIDTH-1:0]  rresp_q, bresp_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic [63:0]             mtime, mtimecmp;
   logic                    wr_en;

   assign ar_hs = bus.arvalid && bus.aready;
   assign r_hs  = bus.rvalid && bus.rready;
   assign aw_hs = bus.awvalid && bus.awready;
   assign w_hs  = bus.wvalid && bus.wready;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state <= R_IDLE;
         wr_state <= W_IDLE;
      end else begin
         rd_state <= rd_next;
         wr_state <= wr_next;
      end
   end

   always_comb begin
      rd_next    = rd_state;
      bus.aready = 1'b0;
      bus.rvalid = 1'b0;
      case (rd_state)
         R_IDLE: begin
            bus.aready = 1'b1;
            if (bus.arvalid) rd_next = R_DATA;
         end
         R_DATA: begin
            bus.rvalid = 1'b1;
            if (bus.rready) rd_next = R_IDLE;
         end
         default: rd_next = R_IDLE;
      endcase
   end

   always_comb begin
      wr_next     = wr_state;
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      case (wr_state)
         W_IDLE: begin
            bus.awready = 1'b1;
            if (bus.awvalid) wr_next = W_DATA;
         end
         W_DATA: begin
            bus.wready = 1'b1;
            if (bus.wvalid) wr_next = W_RESP;
         end
         W_RESP: begin
            bus.bvalid = 1'b1;
            if (bus.bready) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   assign rd_sel = decode_offset(bus.araddr - BASE);
   assign wr_sel = decode_offset(awaddr_q - BASE);

   always_comb begin
      rd_word = '0;
      case (rd_sel)
         SEL_CMP_LO:   rd_word = mtimecmp[31:0];
         SEL_CMP_HI:   rd_word = mtimecmp[63:32];
         SEL_MTIME_LO: rd_word = mtime[31:0];
         SEL_MTIME_HI: rd_word = mtime[63:32];
         default:      rd_word = '0;
      endcase
   end

   // rdata returns to zero once the beat is accepted so it reads 0 while idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
         rresp_q <= OKAY;
      end else if (ar_hs) begin
         rdata_q <= rd_word;
         rresp_q <= (rd_sel == SEL_NONE) ? SLVERR : OKAY;
      end else if (r_hs) begin
         rdata_q <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (aw_hs) awaddr_q <= bus.awaddr;
   end

   always_ff @(posedge clk) begin
      if (reset)     bresp_q <= OKAY;
      else if (w_hs) bresp_q <= (wr_sel == SEL_NONE) ? SLVERR : OKAY;
   end

   assign bus.rdata = rdata_q;
   assign bus.rresp = rresp_q;
   assign bus.bresp = bresp_q;
   assign wr_en     = w_hs && (|bus.wstrb) && (wr_sel != SEL_NONE);

   ysyx_23060184_clint_timer #(
      .TICK_DIV (TICK_DIV)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_data   (bus.wdata),
      .wr_strb   (bus.wstrb),
      .mtime     (mtime),
      .mtimecmp  (mtimecmp),
      .timer_irq (timer_irq)
   );
endmodule

// File: tb/tb_ysyx_23060184_clint.sv
// Directed bench for the CLINT: reset state, counting, wrap, interrupt timing,
// error responses, byte-merge table, back-pressure and mid-transaction reset.
module tb_ysyx_23060184_clint;
   localparam logic [31:0] BASE = 32'h0200_0000;
   localparam logic [31:0] A_CMP_LO = BASE + 32'h4000;
   localparam logic [31:0] A_CMP_HI = BASE + 32'h4004;
   localparam logic [31:0] A_MT_LO  = BASE + 32'hBFF8;
   localparam logic [31:0] A_MT_HI  = BASE + 32'hBFFC;

   logic clk = 1'b0;
   logic reset;
   logic timer_irq;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   ysyx_23060184_clint_if bus ();

   ysyx_23060184_clint #(.TICK_DIV(1), .BASE(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [1:0]  exp_bresp;
      logic [31:0] raddr;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Read with optional back-pressure; exp_* are what the held beat must show while stalled.
   task automatic axi_read(input logic [31:0] addr, input int stall, input logic [31:0] exp_d,
                           input logic [1:0] exp_r, output logic [31:0] data,
                           output logic [1:0] resp, output int hs);
      int n = 0;
      @(negedge clk);
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      bus.rready  = (stall == 0);
      while (!bus.aready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ar_ready", bus.aready, 1'b1);
      hs = cyc + 1;
      @(negedge clk);
      bus.arvalid = 1'b0;
      check("rvalid_latency", bus.rvalid, 1'b1);
      data = bus.rdata;
      resp = bus.rresp;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("r_stall_rvalid", bus.rvalid, 1'b1);
         check("r_stall_rdata", bus.rdata, exp_d);
         check("r_stall_rresp", bus.rresp, exp_r);
         check("r_stall_aready", bus.aready, 1'b0);
      end
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      check("r_done_rvalid", bus.rvalid, 1'b0);
      check("r_idle_rdata", bus.rdata, 32'h0);
      check("r_idle_aready", bus.aready, 1'b1);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int stall, input logic [1:0] exp_b,
                            output logic [1:0] resp, output int hs);
      int n = 0;
      @(negedge clk);
      bus.awaddr  = addr;
      bus.awvalid = 1'b1;
      bus.bready  = 1'b0;
      while (!bus.awready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("aw_ready", bus.awready, 1'b1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      check("w_ready", bus.wready, 1'b1);
      bus.wdata  = data;
      bus.wstrb  = strb;
      bus.wvalid = 1'b1;
      hs = cyc + 1;
      @(negedge clk);
      bus.wvalid = 1'b0;
      check("bvalid_latency", bus.bvalid, 1'b1);
      resp = bus.bresp;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("b_stall_bvalid", bus.bvalid, 1'b1);
         check("b_stall_bresp", bus.bresp, exp_b);
         check("b_stall_awready", bus.awready, 1'b0);
      end
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      check("b_done_bvalid", bus.bvalid, 1'b0);
      check("b_idle_awready", bus.awready, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      vec_t        vecs[8];
      logic [31:0] d;
      logic [1:0]  r;
      logic [63:0] exp64;
      int          hs, hs_w, hs_m, rel, seen, n;

      vecs[0] = '{A_CMP_LO, 32'h1122_3344, 4'b1111, 2'b00, A_CMP_LO, 32'h1122_3344, 2'b00};
      vecs[1] = '{A_CMP_LO, 32'hAABB_CCDD, 4'b0101, 2'b00, A_CMP_LO, 32'h11BB_33DD, 2'b00};
      vecs[2] = '{A_CMP_LO, 32'h5566_7788, 4'b1010, 2'b00, A_CMP_LO, 32'h55BB_77DD, 2'b00};
      vecs[3] = '{A_CMP_LO, 32'h0000_0000, 4'b0000, 2'b00, A_CMP_LO, 32'h55BB_77DD, 2'b00};
      vecs[4] = '{A_CMP_HI, 32'hDEAD_BEEF, 4'b1100, 2'b00, A_CMP_HI, 32'hDEAD_0000, 2'b00};
      vecs[5] = '{BASE + 32'h4001, 32'hFFFF_FFFF, 4'b1111, 2'b10, A_CMP_HI, 32'hDEAD_0000, 2'b00};
      vecs[6] = '{BASE + 32'h8000, 32'hFFFF_FFFF, 4'b1111, 2'b10, BASE + 32'hBFF9, 32'h0, 2'b10};
      vecs[7] = '{A_CMP_HI, 32'h0000_BEEF, 4'b0011, 2'b00, A_CMP_HI, 32'hDEAD_BEEF, 2'b00};

      reset = 1'b1;
      bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0;
      bus.wstrb = '0;  bus.wvalid = 1'b0;  bus.bready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_aready", bus.aready, 1'b1);
      check("rst_awready", bus.awready, 1'b1);
      check("rst_wready", bus.wready, 1'b0);
      check("rst_rvalid", bus.rvalid, 1'b0);
      check("rst_bvalid", bus.bvalid, 1'b0);
      check("rst_rdata", bus.rdata, 32'h0);
      check("rst_rresp", bus.rresp, 2'b00);
      check("rst_bresp", bus.bresp, 2'b00);
      check("rst_irq", timer_irq, 1'b0);

      // Ten counting edges after release, then the read handshake latches 10.
      reset = 1'b0;
      rel = cyc;
      repeat (9) @(negedge clk);
      axi_read(A_MT_LO, 0, 0, 0, d, r, hs);
      check("count_hs_cycle", hs - rel, 11);
      check("count_rdata", d, 32'd10);
      check("count_rresp", r, 2'b00);
      axi_read(A_MT_HI, 0, 0, 0, d, r, hs);
      check("count_hi", d, 32'h0);

      // Wrap: hi first so the carry from the low word cannot disturb it.
      axi_write(A_MT_HI, 32'hFFFF_FFFF, 4'hF, 0, 0, r, hs_w);
      check("wrap_bresp_hi", r, 2'b00);
      axi_write(A_MT_LO, 32'hFFFF_FFFF, 4'hF, 0, 0, r, hs_w);
      check("wrap_bresp_lo", r, 2'b00);
      axi_read(A_MT_LO, 0, 0, 0, d, r, hs);
      exp64 = 64'hFFFF_FFFF_FFFF_FFFF + 64'(hs - 1 - hs_w);
      check("wrap_lo", d, exp64[31:0]);
      check("wrap_rresp", r, 2'b00);
      axi_read(A_MT_HI, 0, 0, 0, d, r, hs);
      exp64 = 64'hFFFF_FFFF_FFFF_FFFF + 64'(hs - 1 - hs_w);
      check("wrap_hi", d, exp64[63:32]);
      check("wrap_irq_low", timer_irq, 1'b0);

      // Interrupt: mtime restarted at 0, compare = 50, irq one edge after mtime hits 50.
      axi_write(A_MT_LO, 32'h0, 4'hF, 0, 0, r, hs_m);
      axi_write(A_CMP_HI, 32'h0, 4'hF, 0, 0, r, hs);
      axi_write(A_CMP_LO, 32'd50, 4'hF, 0, 0, r, hs);
      check("irq_before", timer_irq, 1'b0);
      seen = -1;
      n = 0;
      while (seen < 0 && n < 200) begin
         @(negedge clk);
         if (timer_irq) seen = cyc;
         n++;
      end
      check("irq_rise_cycle", seen - hs_m, 51);

      // Error responses leave the registers untouched.
      axi_write(BASE, 32'h1234_5678, 4'hF, 0, 0, r, hs);
      check("err_bresp", r, 2'b10);
      axi_read(BASE + 32'h4002, 0, 0, 0, d, r, hs);
      check("err_rresp", r, 2'b10);
      check("err_rdata", d, 32'h0);
      axi_read(A_CMP_LO, 0, 0, 0, d, r, hs);
      check("err_cmp_kept", d, 32'd50);

      for (int i = 0; i < 8; i++) begin
         axi_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, 0, 0, r, hs);
         check($sformatf("vec%0d_bresp", i), r, vecs[i].exp_bresp);
         axi_read(vecs[i].raddr, 0, 0, 0, d, r, hs);
         check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
         check($sformatf("vec%0d_rresp", i), r, vecs[i].exp_rresp);
      end
      repeat (2) @(negedge clk);
      check("irq_cleared", timer_irq, 1'b0);

      // Back-pressure on both response channels.
      axi_read(A_CMP_LO, 5, 32'h55BB_77DD, 2'b00, d, r, hs);
      check("stall_rdata", d, 32'h55BB_77DD);
      axi_write(BASE, 32'h0, 4'hF, 5, 2'b10, r, hs);
      check("stall_bresp", r, 2'b10);

      // Reset while in W_DATA aborts the write.
      @(negedge clk);
      bus.awaddr  = A_CMP_LO;
      bus.awvalid = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0;
      check("abort_wready", bus.wready, 1'b1);
      bus.wdata  = 32'h0000_0005;
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      reset      = 1'b1;
      @(negedge clk);
      bus.wvalid = 1'b0;
      check("abort_bvalid", bus.bvalid, 1'b0);
      check("abort_awready", bus.awready, 1'b1);
      check("abort_wready_low", bus.wready, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      rel = cyc;
      check("abort_bvalid2", bus.bvalid, 1'b0);
      axi_read(A_CMP_LO, 0, 0, 0, d, r, hs);
      check("abort_cmp", d, 32'hFFFF_FFFF);
      axi_read(A_MT_LO, 0, 0, 0, d, r, hs);
      check("abort_mtime", d, 32'(hs - 1 - rel));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_23060184_clint.md
YSYX_23060184_CLINT -- requirements
Module: ysyx_23060184_clint

Interface
REQ-001 Parameter TICK_DIV, 1, clk cycles per mtime increment (>=1).
REQ-002 Parameter BASE, 32'h0200_0000, CLINT base address.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 araddr  in  32  read address.
REQ-006 arvalid  in  1  read address valid.
REQ-007 aready  out  1  read address ready.
REQ-008 rdata  out  32  read data.
REQ-009 rresp  out  2  read response.
REQ-010 rvalid  out  1  read data valid.
REQ-011 rready  in  1  master ready for read data.
REQ-012 awaddr  in  32  write address.
REQ-013 awvalid  in  1  write address valid.
REQ-014 awready  out  1  write address ready.
REQ-015 wdata  in  32  write data.
REQ-016 wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
REQ-017 wvalid  in  1  write data valid.
REQ-018 wready  out  1  write data ready.
REQ-019 bvalid  out  1  write response valid.
REQ-020 bresp  out  2  write response.
REQ-021 bready  in  1  master ready for response.
REQ-022 timer_irq  out  1  machine timer interrupt request.

Function
REQ-023 Registers: mtime (64b) at BASE+0xBFF8 (lo) / +0xBFFC (hi); mtimecmp (64b) at BASE+0x4000 (lo) / +0x4004 (hi).
REQ-024 mtime SHALL increment by 1 every TICK_DIV cycles via a prescale counter; wraps 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-025 timer_irq SHALL be registered: (mtime >= mtimecmp, unsigned 64b) sampled one cycle earlier.
REQ-026 Read FSM states R_IDLE, R_DATA; R_IDLE: aready=1, rvalid=0.
REQ-027 R_IDLE, arvalid&&aready: latch selected register value of that cycle into rdata, go R_DATA next cycle (aready=0, rvalid=1).
REQ-028 R_DATA: rdata/rresp held stable until rvalid&&rready, then R_IDLE next cycle; rdata SHALL be 0 in R_IDLE.
REQ-029 Read of any unmapped or non-word-aligned address: rdata=0, rresp=2'b10 (SLVERR); mapped: rresp=2'b00 (OKAY).
REQ-030 Write FSM states W_IDLE, W_DATA, W_RESP; W_IDLE: awready=1, wready=0, bvalid=0.
REQ-031 W_IDLE, awvalid&&awready: latch awaddr, go W_DATA (awready=0, wready=1).
REQ-032 W_DATA, wvalid&&wready: byte-merge wdata into target word per wstrb in that cycle, go W_RESP (wready=0, bvalid=1).
REQ-033 W_RESP: bresp held until bvalid&&bready, then W_IDLE next cycle.
REQ-034 Write to unmapped/misaligned address: no state change, bresp=2'b10; else bresp=2'b00; wstrb=0 is OKAY with no change.
REQ-035 Write to mtime word and tick in same cycle: written word takes written value, other word unchanged, no increment that cycle; prescale counter restarts at 0.
REQ-036 Read and write channels SHALL operate independently and concurrently; a read latched in the same cycle as a write returns the pre-write value.
REQ-037 Throughput: one read per 2 cycles min, one write per 3 cycles min.

Reset
REQ-038 On reset: aready=1, awready=1, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, timer_irq=0, mtime=0, prescale=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, FSMs to R_IDLE/W_IDLE.
REQ-039 Reset asserted mid-transaction SHALL abort it with no response and no register update; values above take effect on the next edge.

Structure
REQ-040 Shared config package holds DATA_WIDTH=32, ACERR_WIDTH=2, WMASK_LENGTH=4, CLINT address offsets, response codes OKAY/SLVERR.
REQ-041 One sub-module: ysyx_23060184_clint_timer (prescaler, 64b mtime, word write port, compare/irq); AXI FSMs in top.

Verification
REQ-042 Reset, TICK_DIV=1, idle 10 cycles, read BASE+0xBFF8 -> rresp=00, rdata = cycle count at AR handshake (10), rvalid one cycle after handshake.
REQ-043 Write mtime lo=0xFFFF_FFFF, hi=0xFFFF_FFFF, wait 2 ticks -> mtime wraps to 1, no error, timer_irq stays 0 with mtimecmp=all-ones.
REQ-044 Write mtimecmp=64'd50 (hi first) -> timer_irq rises exactly one cycle after mtime reaches 50.
REQ-045 Write BASE+0x0 and read BASE+0x4002 -> bresp=10, rresp=10, rdata=0, registers unchanged.
REQ-046 Hold rready=0 for 5 cycles after rvalid; bready=0 for 5 cycles after bvalid -> rdata/rresp/bresp stable, aready/awready stay 0 until handshake.
REQ-047 Assert reset in W_DATA after AW handshake -> no bvalid, mtime=0, awready=1 next cycle.
